store_merge_unit: RTL and testbench

Write-side counterpart of the load extraction path. It takes a store request (word, halfword or byte) from the control unit and drives the word-addressed memory's Address/Wr/Datain port. Sub-word stores use read-modify-write: the block reads the containing word, merges the new bytes in, and writes the word back. It sits between RegB/ALUOut and the memory, sharing the memory port with instruction/data fetch under control-unit arbitration.

---
 rtl/store_merge_unit.sv | 153 +++++++++++++++
 tb/tb_store_merge_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// store_merge_unit: write-side store path between RegB/ALUOut and the
// word-addressed memory. Word stores are written straight through;
// halfword and byte stores read the containing word, merge the new bytes
// in (little-endian lanes) and write the whole word back. Misaligned
// requests are rejected with a one-cycle pulse and never touch memory.
module store_merge_unit #(
  parameter int READ_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Size,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  input  logic [31:0] MemDataOut,
  output logic [31:0] MemAddr,
  output logic        MemWr,
  output logic [31:0] MemDataIn,
  output logic        Busy,
  output logic        Done,
  output logic        Misaligned
);

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    READ,
    WRITE,
    DONE
  } state_t;

  localparam int CW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    size_q;
  logic [1:0]    offset_q;
  logic [31:0]   data_q;

  logic          word_req;
  logic          misaligned_req;
  logic [31:0]   merged;

  // Classify the incoming request: size 11 behaves as a word store
  always_comb begin
    word_req       = (Size == 2'b00) || (Size == 2'b11);
    misaligned_req = 1'b0;
    if (word_req) begin
      misaligned_req = (Addr[1:0] != 2'b00);
    end else if (Size == 2'b01) begin
      misaligned_req = Addr[0];
    end
  end

  // Merge the latched sub-word data into the word currently read back
  always_comb begin
    merged = MemDataOut;
    case (size_q)
      2'b01: begin
        if (offset_q[1]) begin
          merged[31:16] = data_q[15:0];
        end else begin
          merged[15:0] = data_q[15:0];
        end
      end
      2'b10: begin
        case (offset_q)
          2'b00:   merged[7:0]   = data_q[7:0];
          2'b01:   merged[15:8]  = data_q[7:0];
          2'b10:   merged[23:16] = data_q[7:0];
          default: merged[31:24] = data_q[7:0];
        endcase
      end
      default: merged = data_q;
    endcase
  end

  // Control FSM; every output is registered here. MemDataIn doubles as the
  // merge buffer, so the merged word is captured on the edge that ends the
  // last READ cycle and is already stable while MemWr is high.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      size_q     <= 2'b00;
      offset_q   <= 2'b00;
      data_q     <= 32'h0;
      MemAddr    <= 32'h0;
      MemWr      <= 1'b0;
      MemDataIn  <= 32'h0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Misaligned <= 1'b0;
    end else begin
      Done       <= 1'b0;
      Misaligned <= 1'b0;
      MemWr      <= 1'b0;
      case (state)
        IDLE: begin
          MemAddr <= 32'h0;
          Busy    <= 1'b0;
          if (Start) begin
            size_q   <= Size;
            offset_q <= Addr[1:0];
            data_q   <= StoreData;
            Busy     <= 1'b1;
            if (misaligned_req) begin
              state      <= ERR;
              Misaligned <= 1'b1;
            end else if (word_req) begin
              state     <= WRITE;
              MemAddr   <= {Addr[31:2], 2'b00};
              MemWr     <= 1'b1;
              MemDataIn <= StoreData;
            end else begin
              state    <= READ;
              MemAddr  <= {Addr[31:2], 2'b00};
              wait_cnt <= CW'(READ_WAIT - 1);
            end
          end
        end
        ERR: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        READ: begin
          if (wait_cnt == '0) begin
            state     <= WRITE;
            MemWr     <= 1'b1;
            MemDataIn <= merged;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        WRITE: begin
          state <= DONE;
          Done  <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          Busy    <= 1'b0;
          MemAddr <= 32'h0;
        end
        default: begin
          state   <= IDLE;
          Busy    <= 1'b0;
          MemAddr <= 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// tb_store_merge_unit: self-checking bench for store_merge_unit. A small
// word memory model answers reads and absorbs writes; every expected write
// is queued when the request is driven and popped when MemWr is observed.
module tb_store_merge_unit;

  localparam int RW = 2;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [1:0]  Size;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic [31:0] MemDataOut;
  logic [31:0] MemAddr;
  logic        MemWr;
  logic [31:0] MemDataIn;
  logic        Busy;
  logic        Done;
  logic        Misaligned;

  logic [31:0] mem [0:63];
  wr_t         sbQueue[$];
  int          total;
  int          bad;

  store_merge_unit #(.READ_WAIT(RW)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Size       (Size),
    .Addr       (Addr),
    .StoreData  (StoreData),
    .MemDataOut (MemDataOut),
    .MemAddr    (MemAddr),
    .MemWr      (MemWr),
    .MemDataIn  (MemDataIn),
    .Busy       (Busy),
    .Done       (Done),
    .Misaligned (Misaligned)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Memory read port is combinational on the word address
  assign MemDataOut = mem[MemAddr[7:2]];

  // Memory write port commits on the rising edge
  always @(posedge Clk) begin
    if (MemWr) mem[MemAddr[7:2]] <= MemDataIn;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest queued request
  always @(negedge Clk) begin
    if (MemWr) begin
      if (sbQueue.size() == 0) begin
        checkOutput("unexpectedWrite", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = sbQueue.pop_front();
        checkOutput("wrAddr", MemAddr, e.addr);
        checkOutput("wrData", MemDataIn, e.data);
      end
    end
    if (Done || Misaligned) checkOutput("doneMisExclusive", {31'b0, Done & Misaligned}, 32'd0);
  end

  // Independent byte-lane model of the merged word
  function automatic logic [31:0] modelMerge(input logic [1:0] size, input logic [1:0] off,
                                             input logic [31:0] old, input logic [31:0] data);
    logic [3:0]  be;
    logic [31:0] shifted;
    logic [31:0] r;
    if (size == 2'b10) begin
      be      = 4'b0001 << off;
      shifted = {24'b0, data[7:0]} << (8 * off);
    end else if (size == 2'b01) begin
      be      = 4'b0011 << off;
      shifted = {16'b0, data[15:0]} << (8 * off);
    end else begin
      be      = 4'hF;
      shifted = data;
    end
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? shifted[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  // Drive one request at the next falling edge (the block must be idle
  // there), then measure the cycle of MemWr, Done, Misaligned and the
  // number of Busy cycles, counting cycle 1 as the one after the Start edge.
  task automatic applyStimulus(input string tag, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] data, input logic [31:0] expData,
                               input int expWr, input int expDone, input int expMis);
    int wrCyc;
    int doneCyc;
    int misCyc;
    int busyCnt;
    wr_t e;
    @(negedge Clk);
    checkOutput({tag, ".idleBusy"}, {31'b0, Busy}, 32'd0);
    checkOutput({tag, ".idleAddr"}, MemAddr, 32'h0);
    Start     = 1'b1;
    Size      = size;
    Addr      = addr;
    StoreData = data;
    if (expWr > 0) begin
      e.addr = {addr[31:2], 2'b00};
      e.data = expData;
      sbQueue.push_back(e);
    end
    @(posedge Clk);
    #1 Start = 1'b0;
    wrCyc   = -1;
    doneCyc = -1;
    misCyc  = -1;
    busyCnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clk);
      if (MemWr && wrCyc < 0) wrCyc = c;
      if (Done && doneCyc < 0) doneCyc = c;
      if (Misaligned && misCyc < 0) misCyc = c;
      if (Busy) busyCnt++;
      if (Done || Misaligned) break;
    end
    checkOutput({tag, ".wrCycle"}, wrCyc, expWr);
    checkOutput({tag, ".doneCycle"}, doneCyc, expDone);
    checkOutput({tag, ".misCycle"}, misCyc, expMis);
    checkOutput({tag, ".busyCycles"}, busyCnt, (expDone > 0) ? expDone : expMis);
  endtask

  // Main sequence
  initial begin
    int doneCyc;
    total     = 0;
    bad       = 0;
    Reset     = 1'b0;
    Start     = 1'b0;
    Size      = 2'b00;
    Addr      = 32'h0;
    StoreData = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[8] = 32'h12345678;

    repeat (2) @(posedge Clk);
    #1;
    checkOutput("rst.MemAddr", MemAddr, 32'h0);
    checkOutput("rst.MemWr", {31'b0, MemWr}, 32'd0);
    checkOutput("rst.MemDataIn", MemDataIn, 32'h0);
    checkOutput("rst.Busy", {31'b0, Busy}, 32'd0);
    checkOutput("rst.Done", {31'b0, Done}, 32'd0);
    checkOutput("rst.Misaligned", {31'b0, Misaligned}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    // Word store goes straight to WRITE
    applyStimulus("word", 2'b00, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1, 2, -1);

    // Byte and halfword read-modify-write stores on the same memory word
    mem[4] = 32'hAABBCCDD;
    applyStimulus("byte", 2'b10, 32'h12, 32'h11223344, 32'hAA44CCDD, RW + 1, RW + 2, -1);
    mem[4] = 32'hAABBCCDD;
    applyStimulus("halfHi", 2'b01, 32'h12, 32'h11223344, 32'h3344CCDD, RW + 1, RW + 2, -1);
    mem[4] = 32'hAABBCCDD;
    applyStimulus("halfLo", 2'b01, 32'h10, 32'h11223344, 32'hAABB3344, RW + 1, RW + 2, -1);
    checkOutput("halfLo.mem", mem[4], 32'hAABB3344);

    // Misaligned requests are rejected without any memory access
    applyStimulus("misHalf", 2'b01, 32'h13, 32'h55667788, 32'h0, -1, -1, 1);
    applyStimulus("misWord", 2'b00, 32'h02, 32'h55667788, 32'h0, -1, -1, 1);
    applyStimulus("sizeThreeWord", 2'b11, 32'h14, 32'h0BADCAFE, 32'h0BADCAFE, 1, 2, -1);

    // Start during READ must not disturb the latched request
    @(negedge Clk);
    mem[4]    = 32'hAABBCCDD;
    Start     = 1'b1;
    Size      = 2'b10;
    Addr      = 32'h12;
    StoreData = 32'h11223344;
    sbQueue.push_back('{addr: 32'h10, data: 32'hAA44CCDD});
    @(posedge Clk);
    #1 Start = 1'b0;
    @(negedge Clk);
    Start     = 1'b1;
    Size      = 2'b00;
    Addr      = 32'h40;
    StoreData = 32'hCAFEF00D;
    @(posedge Clk);
    #1 Start = 1'b0;
    doneCyc = -1;
    for (int c = 2; c <= 12; c++) begin
      @(negedge Clk);
      if (Done) begin
        doneCyc = c;
        break;
      end
    end
    checkOutput("busyStart.doneCycle", doneCyc, RW + 2);
    checkOutput("busyStart.mem40", mem[16], 32'h0);
    // Back-to-back request in the cycle right after Done
    applyStimulus("afterDone", 2'b00, 32'h44, 32'h0F0F0F0F, 32'h0F0F0F0F, 1, 2, -1);

    // Reset during the second READ cycle aborts without a write
    @(negedge Clk);
    Start     = 1'b1;
    Size      = 2'b10;
    Addr      = 32'h21;
    StoreData = 32'h000000EE;
    @(posedge Clk);
    #1 Start = 1'b0;
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    checkOutput("midRst.MemWr", {31'b0, MemWr}, 32'd0);
    checkOutput("midRst.MemAddr", MemAddr, 32'h0);
    checkOutput("midRst.MemDataIn", MemDataIn, 32'h0);
    checkOutput("midRst.Busy", {31'b0, Busy}, 32'd0);
    checkOutput("midRst.Done", {31'b0, Done}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (4) @(negedge Clk);
    checkOutput("midRst.memKept", mem[8], 32'h12345678);
    applyStimulus("postRst", 2'b00, 32'h20, 32'h76543210, 32'h76543210, 1, 2, -1);
    checkOutput("postRst.mem", mem[8], 32'h76543210);

    // Random aligned stores checked against the byte-lane model
    for (int n = 0; n < 10; n++) begin
      logic [1:0]  sz;
      logic [1:0]  off;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] idx;
      sz  = 2'($urandom_range(0, 3));
      idx = $urandom_range(20, 31);
      d   = $urandom;
      if (sz == 2'b01)      off = {1'($urandom_range(0, 1)), 1'b0};
      else if (sz == 2'b10) off = 2'($urandom_range(0, 3));
      else                  off = 2'b00;
      mem[idx[5:0]] = $urandom;
      a = {idx[29:0], off};
      if (sz == 2'b00 || sz == 2'b11)
        applyStimulus("rndWord", sz, a, d, modelMerge(sz, off, mem[idx[5:0]], d), 1, 2, -1);
      else
        applyStimulus("rndSub", sz, a, d, modelMerge(sz, off, mem[idx[5:0]], d), RW + 1, RW + 2, -1);
    end

    @(negedge Clk);
    checkOutput("final.Busy", {31'b0, Busy}, 32'd0);
    checkOutput("final.queueEmpty", sbQueue.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so a stuck design cannot hang the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
